// File: rtl/vga_timing_rx_if.sv
// Sync inputs and recovered-timing outputs of the VGA timing receiver.
// The master side drives the sampled sync pins; the slave side is the receiver.
interface vga_timing_rx_if;
    logic       pix_en;
    logic       hsync;
    logic       vsync;
    logic [9:0] x;
    logic [9:0] y;
    logic       active;
    logic       locked;
    logic       frame_tick;
    logic       h_err;
    logic       v_err;

    modport master (
        output pix_en, hsync, vsync,
        input  x, y, active, locked, frame_tick, h_err, v_err
    );

    modport slave (
        input  pix_en, hsync, vsync,
        output x, y, active, locked, frame_tick, h_err, v_err
    );
endinterface

// File: rtl/vga_timing_rx.sv
// Receive-side VGA timing monitor: recovers x/y from hsync/vsync, checks line and
// frame lengths, and reports lock after a run of clean frames.
module vga_timing_rx #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned V_TOTAL     = 521,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 29,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic           clk,
    input  logic           rst,
    vga_timing_rx_if.slave bus
);
    localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);

    localparam logic [9:0]    CNT_MAX   = '1;
    localparam logic [9:0]    CNT_NEAR  = 10'd1022;
    localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]    X_START   = 10'(H_SYNC + H_BP);
    localparam logic [9:0]    X_END     = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0]    Y_START   = 10'(V_SYNC + V_BP);
    localparam logic [9:0]    Y_END     = 10'(V_SYNC + V_BP + V_ACT);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} rxState;

    rxState        state, stateNext;
    logic [9:0]    hcnt, hcntNext;
    logic [9:0]    vcnt, vcntNext;
    logic          prevH, prevV;
    logic          vpend, vpendNext;
    logic          hSeen, hSeenNext;
    logic          vSeen, vSeenNext;
    logic          frameBad, frameBadNext;
    logic [GW-1:0] good, goodNext, goodInc;

    logic          hFall, vFall, frameStart;
    logic          hErr, vErr, timeout, anyErr, toSearch;
    logic          lockedNext, activeNext;
    logic [9:0]    xNext, yNext;

    logic [9:0]    xR, yR;
    logic          activeR, lockedR, frameTickR, hErrR, vErrR;

    assign bus.x          = xR;
    assign bus.y          = yR;
    assign bus.active     = activeR;
    assign bus.locked     = lockedR;
    assign bus.frame_tick = frameTickR;
    assign bus.h_err      = hErrR;
    assign bus.v_err      = vErrR;

    // Edge detection and counters; only committed on pix_en samples.
    always_comb begin
        hFall      = prevH & ~bus.hsync;
        vFall      = prevV & ~bus.vsync;
        frameStart = hFall & (vFall | vpend);
        hErr       = hFall & hSeen & (hcnt != H_LAST);
        timeout    = hFall & ~frameStart & (vcnt == CNT_NEAR);
        vErr       = (frameStart & vSeen & (vcnt != V_LAST)) | timeout;
        anyErr     = hErr | vErr;

        hcntNext = hcnt;
        if (hFall)                hcntNext = '0;
        else if (hcnt != CNT_MAX) hcntNext = hcnt + 10'd1;

        vcntNext = vcnt;
        if (frameStart)                    vcntNext = '0;
        else if (hFall && vcnt != CNT_MAX) vcntNext = vcnt + 10'd1;

        vpendNext = frameStart ? 1'b0 : (vpend | vFall);
    end

    always_comb begin
        stateNext    = state;
        goodNext     = good;
        frameBadNext = frameBad;
        toSearch     = 1'b0;
        goodInc      = good + GW'(1);

        case (state)
            SEARCH: begin
                if (timeout) begin
                    toSearch = 1'b1;
                end else if (frameStart) begin
                    stateNext    = ACQUIRE;
                    goodNext     = '0;
                    frameBadNext = 1'b0;
                end
            end
            ACQUIRE: begin
                if (timeout) begin
                    toSearch = 1'b1;
                end else if (frameStart) begin
                    // An error anywhere in the frame just closed voids its credit.
                    frameBadNext = 1'b0;
                    if (frameBad | anyErr) begin
                        goodNext = '0;
                    end else begin
                        goodNext = goodInc;
                        if (goodInc == GOOD_LOCK) stateNext = LOCKED;
                    end
                end else if (anyErr) begin
                    goodNext     = '0;
                    frameBadNext = 1'b1;
                end
            end
            LOCKED: begin
                if (anyErr) toSearch = 1'b1;
            end
            default: toSearch = 1'b1;
        endcase

        if (toSearch) stateNext = SEARCH;

        // Edge history restarts on SEARCH entry so the first interval is not judged.
        hSeenNext = toSearch ? 1'b0 : (hSeen | hFall);
        vSeenNext = toSearch ? 1'b0 : (vSeen | frameStart);

        lockedNext = (stateNext == LOCKED);
        activeNext = lockedNext
                   && (hcntNext >= X_START) && (hcntNext < X_END)
                   && (vcntNext >= Y_START) && (vcntNext < Y_END);
        xNext = activeNext ? (hcntNext - X_START) : '0;
        yNext = activeNext ? (vcntNext - Y_START) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SEARCH;
            hcnt       <= '0;
            vcnt       <= '0;
            prevH      <= 1'b1;
            prevV      <= 1'b1;
            vpend      <= 1'b0;
            hSeen      <= 1'b0;
            vSeen      <= 1'b0;
            frameBad   <= 1'b0;
            good       <= '0;
            xR         <= '0;
            yR         <= '0;
            activeR    <= 1'b0;
            lockedR    <= 1'b0;
            frameTickR <= 1'b0;
            hErrR      <= 1'b0;
            vErrR      <= 1'b0;
        end else begin
            frameTickR <= 1'b0;
            hErrR      <= 1'b0;
            vErrR      <= 1'b0;
            if (bus.pix_en) begin
                state      <= stateNext;
                hcnt       <= hcntNext;
                vcnt       <= vcntNext;
                prevH      <= bus.hsync;
                prevV      <= bus.vsync;
                vpend      <= vpendNext;
                hSeen      <= hSeenNext;
                vSeen      <= vSeenNext;
                frameBad   <= frameBadNext;
                good       <= goodNext;
                xR         <= xNext;
                yR         <= yNext;
                activeR    <= activeNext;
                lockedR    <= lockedNext;
                frameTickR <= frameStart;
                hErrR      <= hErr;
                vErrR      <= vErr;
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_rx.sv
// Scoreboard bench for vga_timing_rx on a scaled-down raster; the model tracks
// sample indices of sync edges rather than counters.
module tb_vga_timing_rx;
    localparam int HT = 24;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HA = 16;
    localparam int VT = 14;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VA = 8;
    localparam int LF = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       locked;
        logic       ft;
        logic       he;
        logic       ve;
    } outT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vga_timing_rx_if bus();

    vga_timing_rx #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACT(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACT(VA),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    outT expQ[$];
    outT mExp;
    int  vectors = 0;
    int  miscompares = 0;

    // Reference state: sample index of the last hsync fall, lines since frame start.
    int mIdx, mLastH, mLines, mGood, mMode;
    bit mPrevH, mPrevV, mPend, mHSeen, mVSeen, mDirty;

    task automatic modelStep(input bit r, input bit pe, input bit hs, input bit vs);
        bit hf, vf, err, toS;
        int hc, vc;
        if (r) begin
            mIdx = 0; mLastH = 0; mLines = 0; mGood = 0; mMode = 0;
            mPrevH = 1'b1; mPrevV = 1'b1; mPend = 1'b0;
            mHSeen = 1'b0; mVSeen = 1'b0; mDirty = 1'b0;
            mExp = '0;
        end else if (!pe) begin
            mExp.ft = 1'b0; mExp.he = 1'b0; mExp.ve = 1'b0;
        end else begin
            mIdx++;
            hf = mPrevH && !hs;
            vf = mPrevV && !vs;
            mPrevH = hs; mPrevV = vs;
            mExp.ft = 1'b0; mExp.he = 1'b0; mExp.ve = 1'b0;
            toS = 1'b0;
            if (hf) begin
                if (mHSeen && (mIdx - mLastH) != HT) mExp.he = 1'b1;
                mHSeen = 1'b1;
                mLastH = mIdx;
                if (vf || mPend) begin
                    if (mVSeen && (mLines + 1) != VT) mExp.ve = 1'b1;
                    mExp.ft = 1'b1; mLines = 0; mPend = 1'b0; mVSeen = 1'b1;
                end else begin
                    mLines++;
                    if (mLines == 1023) begin mExp.ve = 1'b1; toS = 1'b1; end
                end
            end else if (vf) begin
                mPend = 1'b1;
            end
            err = mExp.he || mExp.ve;
            case (mMode)
                0: if (mExp.ft) begin mMode = 1; mGood = 0; mDirty = 1'b0; end
                1: if (!toS) begin
                    if (mExp.ft) begin
                        if (mDirty || err) mGood = 0; else mGood++;
                        mDirty = 1'b0;
                        if (mGood == LF) mMode = 2;
                    end else if (err) begin
                        mGood = 0; mDirty = 1'b1;
                    end
                end
                default: if (err) toS = 1'b1;
            endcase
            if (toS) begin mMode = 0; mHSeen = 1'b0; mVSeen = 1'b0; end
            hc = (mIdx - mLastH > 1023) ? 1023 : mIdx - mLastH;
            vc = (mLines > 1023) ? 1023 : mLines;
            mExp.locked = (mMode == 2);
            mExp.active = mExp.locked && hc >= HS + HB && hc < HS + HB + HA
                          && vc >= VS + VB && vc < VS + VB + VA;
            mExp.x = mExp.active ? 10'(hc - (HS + HB)) : '0;
            mExp.y = mExp.active ? 10'(vc - (VS + VB)) : '0;
        end
        expQ.push_back(mExp);
    endtask

    task automatic tick(input bit r, input bit pe, input bit hs, input bit vs);
        @(negedge clk);
        rst = r; bus.pix_en = pe; bus.hsync = hs; bus.vsync = vs;
        modelStep(r, pe, hs, vs);
    endtask

    // One pixel sample, sometimes preceded by idle clocks with junk on the sync pins.
    task automatic pix(input bit hs, input bit vs);
        if ($urandom_range(0, 7) == 0)
            repeat ($urandom_range(1, 3)) tick(1'b0, 1'b0, 1'($urandom), 1'($urandom));
        tick(1'b0, 1'b1, hs, vs);
    endtask

    task automatic frame(input int lines, input int shortLine, input int vsAt, input bit vsOn);
        for (int l = 0; l < lines; l++) begin
            int len;
            len = (l == shortLine) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                int pos;
                bit vs;
                pos = l * HT + h;
                vs = !(vsOn && pos >= vsAt && pos < vsAt + VS * HT);
                pix(h >= HS, vs);
            end
        end
    endtask

    task automatic checkLocked(input bit want, input string name);
        @(posedge clk);
        #2;
        vectors++;
        if (bus.locked !== want) begin
            miscompares++;
            $display("FAIL %s: locked=%0b, required %0b", name, bus.locked, want);
        end
    endtask

    initial begin : monitor
        outT got, e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                got = {bus.x, bus.y, bus.active, bus.locked, bus.frame_tick, bus.h_err, bus.v_err};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL out @%0t: got x=%0d y=%0d act=%0b lock=%0b ft=%0b he=%0b ve=%0b, required x=%0d y=%0d act=%0b lock=%0b ft=%0b he=%0b ve=%0b",
                             $time, got.x, got.y, got.active, got.locked, got.ft, got.he, got.ve,
                             e.x, e.y, e.active, e.locked, e.ft, e.he, e.ve);
                end
            end
        end
    end

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: run still going at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1; bus.pix_en = 1'b0; bus.hsync = 1'b1; bus.vsync = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 1'b1, 1'b1);

        repeat (3) frame(VT, -1, 0, 1'b1);
        checkLocked(1'b1, "initial_lock");

        frame(VT, 5, 0, 1'b1);
        checkLocked(1'b0, "short_line_drop");
        repeat (3) frame(VT, -1, 0, 1'b1);
        checkLocked(1'b1, "short_line_relock");

        repeat (3) frame(VT, -1, HT / 2, 1'b1);
        repeat (3) frame(VT, -1, 0, 1'b1);

        frame(1030, -1, 0, 1'b0);
        checkLocked(1'b0, "vsync_timeout_drop");

        repeat (3) frame(VT, -1, 0, 1'b1);
        frame(6, -1, 0, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) frame(VT, -1, 0, 1'b1);
        checkLocked(1'b1, "reset_relock");

        for (int i = 0; i < 8; i++) begin
            int lines, shortLine, vsAt;
            lines     = ($urandom_range(0, 3) == 0) ? VT - 1 + int'($urandom_range(0, 2)) : VT;
            shortLine = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, VT - 1)) : -1;
            vsAt      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, HT - 1)) : 0;
            frame(lines, shortLine, vsAt, 1'b1);
        end

        @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
